// File: rtl/pasos_pkg.sv
//------------------------------------------------------------------------------
// Module   : pasos_pkg
// Brief    : Shared step codes, FSM states and LFSR helpers for generar_pasos.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pasos_pkg;

    localparam logic [2:0] PASO_REST = 3'd0;
    localparam logic [2:0] PASO_A    = 3'd1;
    localparam logic [2:0] PASO_B    = 3'd2;
    localparam logic [2:0] PASO_C    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] LFSR_TAPS  = 8'hB8;
    localparam logic [7:0] LFSR_RESET = 8'h01;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 8'h00);
    endfunction

    function automatic logic [2:0] map_code(input logic [1:0] b);
        logic [2:0] c;
        case (b)
            2'b00:   c = PASO_REST;
            2'b01:   c = PASO_A;
            2'b10:   c = PASO_B;
            default: c = PASO_C;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/step_fifo.sv
//------------------------------------------------------------------------------
// Module   : step_fifo
// Brief    : Small synchronous FIFO; a push while full is only taken with a pop.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module step_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  c_depth = (AW+1)'(DEPTH);
    localparam logic [AW:0]  c_one   = (AW+1)'(1);
    localparam logic [AW-1:0] c_pone = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign dout      = r_mem[r_rd];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage needs no reset: dout is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + c_pone;
            if (w_do_pop)  r_rd <= r_rd + c_pone;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/generar_pasos.sv
//------------------------------------------------------------------------------
// Module   : generar_pasos
// Brief    : Beat-driven LFSR step-code source feeding a valid/ready FIFO.
//            Optional macro GENERAR_PASOS_NO_REPEAT_EN suppresses repeated steps.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module generar_pasos
    import pasos_pkg::*;
#(
    parameter int BEAT_DIV = 4,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] seed,
    input  logic       seed_load,
    output logic [2:0] step_code,
    output logic       step_valid,
    input  logic       step_ready,
    output logic       beat,
    output logic       busy,
    output logic [7:0] dropped
);

    localparam int            CW          = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CW-1:0] c_beat_last = CW'(BEAT_DIV - 1);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_beat_cnt;
    logic [7:0]    r_lfsr;
    logic [7:0]    w_lfsr_next;
    logic [2:0]    w_raw_code;
    logic [2:0]    w_code;
    logic [2:0]    w_head;
    logic          w_beat;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_enter_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start && !stop) w_state_next = ST_RUN;
            ST_RUN:   if (stop)           w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_empty)        w_state_next = ST_IDLE;
            default:                      w_state_next = ST_IDLE;
        endcase
    end

    assign w_enter_run = (r_state == ST_IDLE) && (w_state_next == ST_RUN);
    assign w_beat      = (r_state == ST_RUN) && (r_beat_cnt == c_beat_last);
    assign w_lfsr_next = lfsr_step(r_lfsr);
    assign w_raw_code  = map_code(w_lfsr_next[1:0]);
    assign w_pop       = !w_empty && step_ready;

`ifdef GENERAR_PASOS_NO_REPEAT_EN
    logic [2:0] r_last;

    // Rotate a repeated non-rest step through A->B->C->A.
    always_comb begin
        w_code = w_raw_code;
        if (w_raw_code != PASO_REST && w_raw_code == r_last) begin
            case (w_raw_code)
                PASO_A:  w_code = PASO_B;
                PASO_B:  w_code = PASO_C;
                default: w_code = PASO_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_last <= PASO_REST;
        else if (w_enter_run)                    r_last <= PASO_REST;
        else if (w_beat && w_code != PASO_REST)  r_last <= w_code;
    end
`else
    assign w_code = w_raw_code;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (w_enter_run) begin
            r_beat_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_beat_cnt <= w_beat ? '0 : r_beat_cnt + c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_RESET;
        end else if (r_state == ST_IDLE && seed_load) begin
            r_lfsr <= (seed == 8'h00) ? LFSR_RESET : seed;
        end else if (w_beat) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // A beat that finds the FIFO full and not draining loses its step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped <= 8'h00;
        end else if (w_beat && w_full && !w_pop && dropped != 8'hFF) begin
            dropped <= dropped + 8'h01;
        end
    end

    step_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_beat),
        .pop   (w_pop),
        .din   (w_code),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign step_code  = w_empty ? PASO_REST : w_head;
    assign step_valid = !w_empty;
    assign beat       = w_beat;
    assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_generar_pasos.sv
//------------------------------------------------------------------------------
// Module   : tb_generar_pasos
// Brief    : Directed bench for generar_pasos with a queue-based step scoreboard.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_generar_pasos;

    localparam int BEAT_DIV = 4;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] seed;
    logic       seed_load;
    logic [2:0] step_code;
    logic       step_valid;
    logic       step_ready;
    logic       beat;
    logic       busy;
    logic [7:0] dropped;

    generar_pasos #(
        .BEAT_DIV (BEAT_DIV),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .seed       (seed),
        .seed_load  (seed_load),
        .step_code  (step_code),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .beat       (beat),
        .busy       (busy),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 run, 2 drain
    int         m_state;
    int         m_cnt;
    logic [7:0] m_lfsr;
    logic [2:0] q[$];
    int         m_dropped;
    logic [2:0] m_last;
    int         m_beats;
    logic [2:0] popped[$];
    logic [2:0] exp4[4] = '{3'd0, 3'd0, 3'd2, 3'd4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] mapc(input logic [1:0] b);
        case (b)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    task automatic model_reset();
        m_state   = 0;
        m_cnt     = 0;
        m_lfsr    = 8'h01;
        q.delete();
        m_dropped = 0;
        m_last    = 3'd0;
    endtask

    // Check outputs for the current cycle, advance the model, move to next negedge.
    task automatic cyc();
        logic       exp_beat;
        logic       was_empty;
        logic [2:0] c;
        exp_beat  = (m_state == 1) && (m_cnt == BEAT_DIV - 1);
        was_empty = (q.size() == 0);
        chk("busy",    busy,       m_state != 0);
        chk("valid",   step_valid, !was_empty);
        chk("code",    step_code,  was_empty ? 3'd0 : q[0]);
        chk("beat",    beat,       exp_beat);
        chk("dropped", dropped,    m_dropped);
        if (!was_empty && step_ready) begin
            popped.push_back(step_code);
            c = q.pop_front();
        end
        if (exp_beat) begin
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
            c = mapc(m_lfsr[1:0]);
`ifdef GENERAR_PASOS_NO_REPEAT_EN
            if (c != 3'd0 && c == m_last) c = (c == 3'd1) ? 3'd2 : (c == 3'd2) ? 3'd4 : 3'd1;
            if (c != 3'd0) m_last = c;
`endif
            m_beats++;
            if (q.size() < DEPTH) q.push_back(c);
            else if (m_dropped < 255) m_dropped++;
        end
        case (m_state)
            0: begin
                if (seed_load) m_lfsr = (seed == 8'h00) ? 8'h01 : seed;
                if (start && !stop) begin
                    m_state = 1;
                    m_cnt   = 0;
                    m_last  = 3'd0;
                end
            end
            1: begin
                m_cnt = exp_beat ? 0 : m_cnt + 1;
                if (stop) m_state = 2;
            end
            default: if (was_empty) m_state = 0;
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_beats(input int n);
        int target;
        int guard;
        target = m_beats + n;
        guard  = 0;
        while (m_beats < target && guard < 200) begin
            cyc();
            guard++;
        end
        chk("beat_budget", 32'(m_beats >= target), 1);
    endtask

    task automatic wait_idle(input int max);
        int g;
        g = 0;
        while (busy && g < max) begin
            cyc();
            g++;
        end
        chk("idle_reached", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; seed = 8'h00;
        seed_load = 1'b0; step_ready = 1'b0;
        m_beats = 0;
        model_reset();
        @(negedge clk);
        chk("rst_valid", step_valid, 0);
        chk("rst_busy",  busy,       0);
        chk("rst_code",  step_code,  0);
        chk("rst_drop",  dropped,    0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle for 20 cycles
        repeat (20) cyc();

        // Seed 01, free-flowing consumer: codes 0,0,2,4
        seed = 8'h01; seed_load = 1'b1;
        cyc();
        seed_load = 1'b0; start = 1'b1; step_ready = 1'b1;
        cyc();
        start = 1'b0;
        popped.delete();
        run_beats(4);
        cyc();
        chk("p2_npops", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) chk("p2_code", popped[i], exp4[i]);

        // Stalled consumer over 6 beats: 4 held, 2 dropped, then drain in order
        step_ready = 1'b0;
        run_beats(6);
        chk("p3_dropped", dropped, 2);
        chk("p3_valid",   step_valid, 1);
        chk("p3_occ",     dut.u_fifo.r_count, 4);
        stop = 1'b1;
        cyc();
        stop = 1'b0; step_ready = 1'b1;
        popped.delete();
        wait_idle(20);
        chk("p3_npops",  popped.size(), 4);
        chk("p3_valid0", step_valid, 0);

        // Full FIFO with a beat coinciding with a pop
        step_ready = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        run_beats(4);
        g = 0;
        while (!(m_state == 1 && m_cnt == BEAT_DIV - 1) && g < 10) begin
            cyc();
            g++;
        end
        step_ready = 1'b1;
        cyc();
        step_ready = 1'b0;
        chk("p4_dropped", dropped, 2);
        chk("p4_occ",     dut.u_fifo.r_count, 4);

        // Stop with 3 queued: busy holds, no beats, idle after the 3rd pop
        step_ready = 1'b1;
        cyc();
        step_ready = 1'b0; stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("p5_busy", busy, 1);
        repeat (8) cyc();
        chk("p5_occ", dut.u_fifo.r_count, 3);
        step_ready = 1'b1;
        popped.delete();
        wait_idle(10);
        chk("p5_npops", popped.size(), 3);

        // Zero seed falls back to 01, so the 0,0,2,4 pattern repeats
        seed = 8'h00; seed_load = 1'b1;
        cyc();
        seed_load = 1'b0; start = 1'b1; step_ready = 1'b1;
        cyc();
        start = 1'b0;
        popped.delete();
        run_beats(4);
        cyc();
        chk("p6_npops", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) chk("p6_code", popped[i], exp4[i]);

        // Asynchronous reset mid-run with a non-empty FIFO
        step_ready = 1'b0;
        run_beats(2);
        chk("p7_valid_pre", step_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("p7_valid", step_valid, 0);
        chk("p7_busy",  busy,       0);
        chk("p7_code",  step_code,  0);
        chk("p7_drop",  dropped,    0);
        chk("p7_beat",  beat,       0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
